// File: rtl/dds_wave_gen.sv
// Phase-accumulator DDS core producing square, triangle and sawtooth samples
// with double-buffered tuning words, midscale attenuation and a 3-stage pipeline.
module dds_wave_gen #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned DATA_W  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PHASE_W-1:0] fword_in,
  input  logic [PHASE_W-1:0] pword_in,
  input  logic               fword_load,
  input  logic [2:0]         amp_shift,
  output logic [DATA_W-1:0]  da_ina,
  output logic [DATA_W-1:0]  da_inb,
  output logic [DATA_W-1:0]  da_inc,
  output logic               valid,
  output logic               cycle_start,
  output logic               load_pending
);

  localparam int unsigned    PH_SHIFT = PHASE_W - DATA_W;
  localparam logic [DATA_W-1:0] MID   = {1'b1, {(DATA_W-1){1'b0}}};

  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] r_fword_act;
  logic [PHASE_W-1:0] r_pword_act;
  logic [PHASE_W-1:0] r_fword_sh;
  logic [PHASE_W-1:0] r_pword_sh;
  logic               r_load_pending;

  logic [DATA_W-1:0]  r_ph;
  logic               r_v1;
  logic               r_w1;

  logic [DATA_W-1:0]  r_sq;
  logic [DATA_W-1:0]  r_tri;
  logic [DATA_W-1:0]  r_saw;
  logic               r_v2;
  logic               r_w2;

  logic [DATA_W-1:0]  r_da_ina;
  logic [DATA_W-1:0]  r_da_inb;
  logic [DATA_W-1:0]  r_da_inc;
  logic               r_valid;
  logic               r_cycle_start;

  logic [PHASE_W:0]   w_sum;
  logic               w_wrap;
  logic               w_apply;
  logic [DATA_W-1:0]  w_sq;
  logic [DATA_W-1:0]  w_tri_base;
  logic [DATA_W-1:0]  w_tri;

  // Offset-binary to signed, arithmetic shift toward midscale, back to offset binary.
  function automatic logic [DATA_W-1:0] f_scale(input logic [DATA_W-1:0] raw,
                                                input logic [2:0]        sh);
    logic signed [DATA_W-1:0] s_v;
    logic signed [DATA_W-1:0] t_v;
    s_v = $signed(raw ^ MID);
    t_v = s_v >>> sh;
    return $unsigned(t_v) ^ MID;
  endfunction

  // Next accumulator value with carry; active words only swap while idle or at a wrap.
  always_comb begin
    w_sum   = {1'b0, r_acc} + {1'b0, r_fword_act};
    w_wrap  = en & w_sum[PHASE_W];
    w_apply = ~en | w_wrap;
  end

  // Raw waveform generation from the registered phase index.
  always_comb begin
    w_sq       = r_ph[DATA_W-1] ? '0 : '1;
    w_tri_base = {r_ph[DATA_W-2:0], 1'b0};
    w_tri      = r_ph[DATA_W-1] ? ~w_tri_base : w_tri_base;
  end

  // Accumulator, shadow and active tuning words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc          <= '0;
      r_fword_act    <= '0;
      r_pword_act    <= '0;
      r_fword_sh     <= '0;
      r_pword_sh     <= '0;
      r_load_pending <= 1'b0;
    end else begin
      if (fword_load) begin
        r_fword_sh <= fword_in;
        r_pword_sh <= pword_in;
      end
      if (w_apply && fword_load) begin
        r_fword_act    <= fword_in;
        r_pword_act    <= pword_in;
        r_load_pending <= 1'b0;
      end else if (w_apply && r_load_pending) begin
        r_fword_act    <= r_fword_sh;
        r_pword_act    <= r_pword_sh;
        r_load_pending <= 1'b0;
      end else if (fword_load) begin
        r_load_pending <= 1'b1;
      end
      if (en) begin
        r_acc <= w_sum[PHASE_W-1:0];
      end
    end
  end

  // Stage 1: phase index with offset, valid and wrap tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph <= '0;
      r_v1 <= 1'b0;
      r_w1 <= 1'b0;
    end else begin
      r_ph <= DATA_W'((r_acc + r_pword_act) >> PH_SHIFT);
      r_v1 <= en;
      r_w1 <= w_wrap;
    end
  end

  // Stage 2: raw square, triangle and sawtooth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sq  <= '0;
      r_tri <= '0;
      r_saw <= '0;
      r_v2  <= 1'b0;
      r_w2  <= 1'b0;
    end else begin
      r_sq  <= w_sq;
      r_tri <= w_tri;
      r_saw <= r_ph;
      r_v2  <= r_v1;
      r_w2  <= r_w1;
    end
  end

  // Stage 3: attenuation about midscale and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_da_ina      <= '0;
      r_da_inb      <= '0;
      r_da_inc      <= '0;
      r_valid       <= 1'b0;
      r_cycle_start <= 1'b0;
    end else begin
      r_da_ina      <= f_scale(r_sq, amp_shift);
      r_da_inb      <= f_scale(r_tri, amp_shift);
      r_da_inc      <= f_scale(r_saw, amp_shift);
      r_valid       <= r_v2;
      r_cycle_start <= r_w2;
    end
  end

  assign da_ina       = r_da_ina;
  assign da_inb       = r_da_inb;
  assign da_inc       = r_da_inc;
  assign valid        = r_valid;
  assign cycle_start  = r_cycle_start;
  assign load_pending = r_load_pending;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: reference model feeding a scoreboard queue,
// a table of spot-check samples, and hand-written retune/reset sequences.
module tb_dds_wave_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [31:0] fword_in = '0;
  logic [31:0] pword_in = '0;
  logic        fword_load = 1'b0;
  logic [2:0]  amp_shift = '0;
  logic [13:0] da_ina, da_inb, da_inc;
  logic        valid, cycle_start, load_pending;

  dds_wave_gen #(.PHASE_W(32), .DATA_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fword_in(fword_in), .pword_in(pword_in),
    .fword_load(fword_load), .amp_shift(amp_shift), .da_ina(da_ina), .da_inb(da_inb),
    .da_inc(da_inc), .valid(valid), .cycle_start(cycle_start), .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] sq;
    logic [13:0] tr;
    logic [13:0] sw;
    logic        v;
    logic        w;
  } raw_t;

  typedef struct {
    logic [2:0]  amp;
    int          idx;
    logic [13:0] a;
    logic [13:0] b;
    logic [13:0] c;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] m_acc, m_fact, m_pact, m_fsh, m_psh;
  logic        m_pend;
  raw_t        sb_q[$];
  logic [13:0] e_a, e_b, e_c;
  logic        e_v, e_w, e_pend;

  logic [13:0] cap_a[16];
  logic [13:0] cap_b[16];
  logic [13:0] seq_s[24];
  vec_t        vt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic raw_t mk_raw(input logic [13:0] ph);
    raw_t r;
    int p;
    p = int'(ph);
    r.sq = (p >= 8192) ? 14'd0 : 14'd16383;
    r.tr = (p < 8192) ? 14'(2 * p) : 14'(16383 - 2 * (p - 8192));
    r.sw = ph;
    r.v = 1'b0;
    r.w = 1'b0;
    return r;
  endfunction

  // midscale-relative floor division by 2^k
  function automatic logic [13:0] scale(input logic [13:0] r, input logic [2:0] k);
    int s, d, t;
    s = int'(r) - 8192;
    d = 1 << k;
    if (s >= 0) t = s / d;
    else t = -((-s + d - 1) / d);
    return 14'(t + 8192);
  endfunction

  task automatic model_reset();
    raw_t z;
    m_acc = '0; m_fact = '0; m_pact = '0; m_fsh = '0; m_psh = '0; m_pend = 1'b0;
    sb_q = {};
    z = '{14'd0, 14'd0, 14'd0, 1'b0, 1'b0};
    sb_q.push_back(z);
    sb_q.push_back(mk_raw(14'd0));
    e_a = '0; e_b = '0; e_c = '0; e_v = 1'b0; e_w = 1'b0; e_pend = 1'b0;
  endtask

  task automatic model_edge();
    logic [32:0] sum;
    logic        wrap, apply;
    logic [31:0] p;
    raw_t        r, f;
    sum   = {1'b0, m_acc} + {1'b0, m_fact};
    wrap  = en & sum[32];
    apply = ~en | wrap;
    p     = m_acc + m_pact;
    r     = mk_raw(p[31:18]);
    r.v   = en;
    r.w   = wrap;
    f     = sb_q.pop_front();
    sb_q.push_back(r);
    e_a = scale(f.sq, amp_shift);
    e_b = scale(f.tr, amp_shift);
    e_c = scale(f.sw, amp_shift);
    e_v = f.v;
    e_w = f.w;
    if (apply && fword_load) begin
      m_fact = fword_in; m_pact = pword_in; m_pend = 1'b0;
    end else if (apply && m_pend) begin
      m_fact = m_fsh; m_pact = m_psh; m_pend = 1'b0;
    end else if (fword_load) begin
      m_pend = 1'b1;
    end
    if (fword_load) begin
      m_fsh = fword_in; m_psh = pword_in;
    end
    if (en) m_acc = sum[31:0];
    e_pend = m_pend;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("sb_ina", da_ina, e_a);
    chk("sb_inb", da_inb, e_b);
    chk("sb_inc", da_inc, e_c);
    chk("sb_valid", valid, e_v);
    chk("sb_cycle_start", cycle_start, e_w);
    chk("sb_load_pending", load_pending, e_pend);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; fword_load = 1'b0;
    #2;
    model_reset();
    chk("rst_ina", da_ina, 0);
    chk("rst_inb", da_inb, 0);
    chk("rst_inc", da_inc, 0);
    chk("rst_valid", valid, 0);
    chk("rst_cycle_start", cycle_start, 0);
    chk("rst_load_pending", load_pending, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_words(input logic [31:0] f, input logic [31:0] p);
    fword_in = f; pword_in = p; fword_load = 1'b1;
    tick();
    fword_load = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] f, input logic [31:0] p, input logic [2:0] amp);
    do_reset();
    amp_shift = amp;
    load_words(f, p);
    en = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int  lat;
    bit  got;
    lat = 0; got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      tick();
      lat++;
      if (valid === 1'b1) got = 1;
    end
    chk(name, lat, 3);
  endtask

  initial begin
    int kf;
    bit bad, found;
    logic [13:0] d;

    vt[0] = '{3'd0, 0,  14'd16383, 14'd0,     14'd0};
    vt[1] = '{3'd0, 1,  14'd16383, 14'd2048,  14'd1024};
    vt[2] = '{3'd0, 8,  14'd0,     14'd16383, 14'd8192};
    vt[3] = '{3'd0, 9,  14'd0,     14'd14335, 14'd9216};
    vt[4] = '{3'd0, 15, 14'd0,     14'd2047,  14'd15360};
    vt[5] = '{3'd0, 16, 14'd16383, 14'd0,     14'd0};
    vt[6] = '{3'd1, 0,  14'd12287, 14'd4096,  14'd4096};
    vt[7] = '{3'd1, 8,  14'd4096,  14'd12287, 14'd8192};
    vt[8] = '{3'd7, 0,  14'd8255,  14'd8128,  14'd8128};
    vt[9] = '{3'd7, 8,  14'd8128,  14'd8255,  14'd8192};

    #1;
    // sweep and attenuation spot checks
    for (int i = 0; i < 10; i++) begin
      start_run(32'h1000_0000, 32'h0, vt[i].amp);
      wait_valid("valid_latency");
      for (int k = 0; k < vt[i].idx; k++) tick();
      chk($sformatf("vec%0d_ina", i), da_ina, vt[i].a);
      chk($sformatf("vec%0d_inb", i), da_inb, vt[i].b);
      chk($sformatf("vec%0d_inc", i), da_inc, vt[i].c);
    end

    // glitch-free retune mid-period
    start_run(32'h1000_0000, 32'h0, 3'd0);
    for (int k = 0; k < 21; k++) tick();
    load_words(32'h2000_0000, 32'h0);
    chk("retune_pending", load_pending, 1);
    for (int j = 0; j < 24; j++) begin
      tick();
      seq_s[j] = da_inc;
    end
    kf = -1; bad = 0;
    for (int j = 1; j < 24; j++) begin
      d = 14'(seq_s[j] - seq_s[j-1]);
      if (kf < 0 && d == 14'd2048) kf = j;
      else if (kf < 0 && d != 14'd1024) bad = 1;
    end
    chk("retune_no_partial", bad, 0);
    if (kf >= 2) chk("retune_boundary", {seq_s[kf-2], seq_s[kf-1]}, {14'd15360, 14'd0});
    else chk("retune_found", kf, 2);

    // load on the wrap edge itself
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_acc == 32'hE000_0000) found = 1;
      else tick();
    end
    chk("wrap_edge_found", found, 1);
    load_words(32'h1000_0000, 32'h0);
    chk("wrap_load_pending", load_pending, 0);
    for (int k = 0; k < 3; k++) tick();
    chk("wrap_load_first", da_inc, 0);
    tick();
    chk("wrap_load_step", da_inc, 1024);

    // phase offset comparison
    start_run(32'h1000_0000, 32'h0, 3'd0);
    wait_valid("valid_latency_p0");
    for (int j = 0; j < 16; j++) begin
      if (j > 0) tick();
      cap_a[j] = da_inc;
    end
    start_run(32'h1000_0000, 32'h4000_0000, 3'd0);
    wait_valid("valid_latency_p1");
    for (int j = 0; j < 16; j++) begin
      if (j > 0) tick();
      cap_b[j] = da_inc;
    end
    for (int j = 0; j < 16; j++)
      chk($sformatf("phase_off%0d", j), 14'(cap_b[j] - cap_a[j]), 4096);

    // async reset with a pending load
    start_run(32'h1000_0000, 32'h0, 3'd0);
    for (int k = 0; k < 5; k++) tick();
    load_words(32'h3000_0000, 32'h0);
    tick();
    chk("pre_reset_pending", load_pending, 1);
    do_reset();
    load_words(32'h1000_0000, 32'h0);
    en = 1'b1;
    wait_valid("valid_latency_restart");
    chk("restart_saw", da_inc, 0);
    tick();
    chk("restart_saw1", da_inc, 1024);

    // valid falls 3 cycles after en falls
    en = 1'b0;
    tick(); tick();
    chk("valid_hold", valid, 1);
    tick();
    chk("valid_fall", valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dds_wave_gen.md
Name: dds_wave_gen

Overview:
Phase-accumulator DDS core that generates the three 14-bit waveforms feeding the downstream waveform selector and DAC path: square, triangle and sawtooth.
- Frequency and phase words are double-buffered and switched glitch-free at the phase wrap.
- A common amplitude attenuation is applied around midscale.
- The pipeline has a fixed 3-cycle latency and provides valid and cycle-start strobes.

Parameters:
PHASE_W, 32, phase accumulator width (bits)
DATA_W, 14, output sample width; also the number of phase MSBs used as the waveform index

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  1 = accumulator advances each clk; 0 = accumulator holds
fword_in  input  PHASE_W  frequency tuning word
pword_in  input  PHASE_W  phase offset word
fword_load  input  1  1-cycle strobe; captures fword_in and pword_in into the shadow registers
amp_shift  input  3  attenuation; output swing is divided by 2^amp_shift about midscale
da_ina  output  DATA_W  square wave, offset binary
da_inb  output  DATA_W  triangle wave, offset binary
da_inc  output  DATA_W  sawtooth wave, offset binary
valid  output  1  outputs carry a sample produced while en=1
cycle_start  output  1  1-cycle pulse on the first output sample after a phase wrap
load_pending  output  1  shadow words captured but not yet applied

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset, all of the following clear to 0:
  - acc, fword_act, pword_act, fword_sh, pword_sh, load_pending
  - pipeline registers
  - da_ina, da_inb, da_inc, valid, cycle_start
- Reset mid-operation aborts immediately, including any pending load and any samples in the pipeline.
- Shadow load: on fword_load=1, fword_sh <= fword_in, pword_sh <= pword_in, and load_pending <= 1. A second load before the apply overwrites the shadow (last wins).
- Apply, when en=1: at the clk edge where acc + fword_act carries out of PHASE_W bits (wrap), with load_pending=1:
  - fword_act <= fword_sh, pword_act <= pword_sh, load_pending <= 0.
  - If fword_load=1 on that same edge, fword_in/pword_in bypass the shadow and go directly to the active registers; load_pending ends at 0.
- Apply, when en=0: any pending or simultaneous load applies on the next edge; acc is not reset.
- Accumulator: if en=1, acc <= (acc + fword_act) mod 2^PHASE_W. This uses the old fword_act on the apply edge. If en=0, acc holds. fword_act=0 with en=1 gives a constant output and no wrap.
- Stage 1: ph <= top DATA_W bits of (acc + pword_act) mod 2^PHASE_W. v1 <= en. w1 <= wrap flag of the acc update.
- Stage 2 (raw waveforms):
  - sq = ph[13] ? 0 : 14'h3FFF.
  - tri = ph[13] ? ~{ph[12:0],0} : {ph[12:0],0}.
  - saw = ph.
- Stage 3 (scaling): for each raw value r, s = r ^ 14'h2000 (signed), t = s >>> amp_shift (arithmetic), out = t ^ 14'h2000.
- Timing: stage 3 registers the three outputs, valid <= v2 and cycle_start <= w2. An acc value appears on the outputs 3 clk later.
- en falling: the pipeline keeps clocking the held acc; valid falls 3 cycles after en falls.
- amp_shift is sampled in stage 3 only, so a change is visible 1 clk later with no glitch.

Test Plan:
1. Basic sweep. Reset, then fword_load with fword_in=32'h1000_0000, pword_in=0, en=0, then en=1 for 32 clk.
   - Period is 16 samples; da_inc = 0, 1024, 2048, … 15360, then repeats.
   - da_ina = 16383 for samples 0–7 and 0 for samples 8–15.
   - da_inb: sample 1 = 2048, sample 8 = 16383, sample 9 = 14335.
   - valid rises 3 clk after en; cycle_start pulses every 16 clk.
2. Attenuation. Same stimulus with amp_shift=1.
   - da_ina alternates 12287 (0x2FFF) and 4096 (0x1000).
   - amp_shift=7 gives a square of 8255/8128.
3. Glitch-free retune. While running at 32'h1000_0000, load 32'h2000_0000 mid-period.
   - load_pending=1 until the next wrap.
   - The saw step stays 1024 until the wrap, then becomes 2048; there is no partial period.
4. Load coinciding with the wrap edge: the new word takes effect on that wrap, and load_pending stays 0.
5. Phase offset. Two runs, pword_in=0 versus 32'h4000_0000, same fword: da_inc differs by 4096 mod 16384 sample-for-sample.
6. Asynchronous reset asserted mid-period with a load pending: all outputs are 0 immediately, load_pending=0, and acc restarts from 0 after release.
